// File: rtl/tft_timing_gen.sv
// tft_timing_gen: RGB parallel-panel timing generator with built-in test patterns.
// Ports: i_clk/i_rst_n (sync, active-low) clock and reset; i_mode selects the pattern
// (0 external, 1 colour bars, 2 checkerboard, 3 gradient); i_Red/i_Green/i_Blue carry
// the external pixel; o_tft_clk/o_HS/o_VS/o_DE/o_Red/o_Green/o_Blue drive the panel;
// o_row_pixel/o_col_pixel give the coordinate fetched for the next tick; o_pix_tick
// and o_frame_start pulse when the panel outputs update.
module tft_timing_gen #(
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 2,
  parameter int H_SYNC    = 41,
  parameter int H_BP      = 2,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 2,
  parameter int V_SYNC    = 10,
  parameter int V_BP      = 2,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CLK_DIV   = 4,
  parameter int COLOR_W   = 8,
  parameter int CHK_SHIFT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_mode,
  input  logic [COLOR_W-1:0] i_Red,
  input  logic [COLOR_W-1:0] i_Green,
  input  logic [COLOR_W-1:0] i_Blue,
  output logic               o_tft_clk,
  output logic               o_HS,
  output logic               o_VS,
  output logic               o_DE,
  output logic [COLOR_W-1:0] o_Red,
  output logic [COLOR_W-1:0] o_Green,
  output logic [COLOR_W-1:0] o_Blue,
  output logic [15:0]        o_row_pixel,
  output logic [15:0]        o_col_pixel,
  output logic               o_pix_tick,
  output logic               o_frame_start
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  logic [DW-1:0]      r_div, w_div_nxt;
  logic [15:0]        r_h, r_v, r_bar_px;
  logic [2:0]         r_bar;
  logic [1:0]         r_mode, w_mode;
  logic               w_tick, w_origin, w_de, w_chk, w_h_wrap;
  logic [COLOR_W-1:0] w_sum, w_red, w_grn, w_blu;

  assign w_tick    = r_div == DIV_LAST;
  assign w_div_nxt = w_tick ? '0 : r_div + 1'b1;
  assign w_origin  = r_h == '0 && r_v == '0;
  assign w_h_wrap  = r_h == H_LAST;
  // The tick that loads pixel (0,0) already uses the newly captured mode.
  assign w_mode    = (w_tick && w_origin) ? i_mode : r_mode;
  assign w_de      = r_h < H_ACT && r_v < V_ACT;
  assign w_chk     = r_h[CHK_SHIFT] ^ r_v[CHK_SHIFT];
  assign w_sum     = COLOR_W'(r_h + r_v);

  // Bar index encodes the colour directly: R = ~bit1, G = ~bit2, B = ~bit0.
  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    if (w_de)
      case (w_mode)
        2'd0: {w_red, w_grn, w_blu} = {i_Red, i_Green, i_Blue};
        2'd1: {w_red, w_grn, w_blu} = {{COLOR_W{~r_bar[1]}}, {COLOR_W{~r_bar[2]}}, {COLOR_W{~r_bar[0]}}};
        2'd2: {w_red, w_grn, w_blu} = {3*COLOR_W{~w_chk}};
        default: {w_red, w_grn, w_blu} = {COLOR_W'(r_h), COLOR_W'(r_v), w_sum};
      endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_bar_px      <= '0;
      r_bar         <= '0;
      r_mode        <= '0;
      o_tft_clk     <= 1'b0;
      o_HS          <= ~HS_ON;
      o_VS          <= ~VS_ON;
      o_DE          <= 1'b0;
      o_Red         <= '0;
      o_Green       <= '0;
      o_Blue        <= '0;
      o_pix_tick    <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      // Registered from the next divider value so the panel clock falls on the tick edge.
      o_tft_clk     <= w_div_nxt >= DIV_HALF;
      o_pix_tick    <= w_tick;
      o_frame_start <= w_tick && w_origin;
      if (w_tick) begin
        r_mode   <= w_mode;
        r_h      <= w_h_wrap ? '0 : r_h + 16'd1;
        if (w_h_wrap) r_v <= r_v == V_LAST ? '0 : r_v + 16'd1;
        // Bar counter tracks the bar of the next pixel; index saturates so bar 7 takes the remainder.
        r_bar_px <= (w_h_wrap || r_bar_px == BAR_LAST) ? '0 : r_bar_px + 16'd1;
        r_bar    <= w_h_wrap ? '0 : (r_bar_px == BAR_LAST && r_bar != 3'd7) ? r_bar + 3'd1 : r_bar;
        o_HS     <= (r_h >= HS_BEG && r_h < HS_END) ? HS_ON : ~HS_ON;
        o_VS     <= (r_v >= VS_BEG && r_v < VS_END) ? VS_ON : ~VS_ON;
        o_DE     <= w_de;
        o_Red    <= w_red;
        o_Green  <= w_grn;
        o_Blue   <= w_blu;
      end
    end
  end

  assign o_col_pixel = r_h;
  assign o_row_pixel = r_v;
endmodule

// File: doc/tft_timing_gen.md
# tft_timing_gen

Parametrised TFT timing generator for RGB parallel panels. It sits between the panel pins and the frame-storage block. It produces the pixel clock, the HS/VS/DE timing and row/column coordinates for any resolution and porch set. It outputs either external pixel data or one of three built-in test patterns, chosen per frame, so panels can be brought up with no frame storage attached.

## Interface
Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (pixels)
- H_SYNC, 41, horizontal sync width (pixels)
- H_BP, 2, horizontal back porch (pixels)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vertical sync width (lines)
- V_BP, 2, vertical back porch (lines)
- HS_POL, 0, active level of o_HS
- VS_POL, 0, active level of o_VS
- CLK_DIV, 4, i_clk cycles per pixel; even, ≥2
- COLOR_W, 8, bits per colour channel
- CHK_SHIFT, 4, checkerboard square size = 2^CHK_SHIFT pixels

Ports:
- i_clk  in  1  system clock; the only clock
- i_rst_n  in  1  synchronous, active-low reset
- i_mode  in  2  0 external, 1 colour bars, 2 checkerboard, 3 gradient
- i_Red / i_Green / i_Blue  in  COLOR_W each  external pixel for the current coordinate
- o_tft_clk  out  1  pixel clock to the panel
- o_HS / o_VS / o_DE  out  1 each  panel sync and data enable
- o_Red / o_Green / o_Blue  out  COLOR_W each  panel pixel data
- o_row_pixel / o_col_pixel  out  16 each  v_cnt / h_cnt of the pixel fetched for the next tick
- o_pix_tick  out  1  one-i_clk pulse at each pixel boundary
- o_frame_start  out  1  one-i_clk pulse coincident with the tick that loads pixel (0,0)

## Operation
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider div_cnt runs 0..CLK_DIV-1. A tick occurs when div_cnt == CLK_DIV-1. o_tft_clk = (div_cnt ≥ CLK_DIV/2), registered.
- Counter h_cnt runs 0..H_TOTAL-1 and advances on each tick. At wrap, h_cnt goes to 0 and v_cnt advances (0..V_TOTAL-1, wraps to 0).
- Region order in both axes: active, front porch, sync, back porch.
- HS is active when h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- VS is active for whole lines with v_cnt ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- DE = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- o_col_pixel = h_cnt and o_row_pixel = v_cnt, zero-extended to 16 bits, taken directly from the counter registers.
- On each tick, all panel outputs load from the pre-increment counters. The external i_Red/i_Green/i_Blue are sampled on that same tick.
- Mode latch: i_mode is captured only on the tick where h_cnt==0 && v_cnt==0. A mode change mid-frame takes effect at the next frame.
- Colour rules apply only when DE is high; outside DE all colours are 0.
  - Colour bars: 8 bars of BAR_W = H_ACTIVE/8 pixels. A bar counter saturates at index 7, so the last bar absorbs the remainder. There is no divider in the datapath.
  - Bar colours, in order: white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or 0.
  - Checkerboard: white when ((col>>CHK_SHIFT) ^ (row>>CHK_SHIFT)) bit 0 is 0, else black.
  - Gradient: Red = col[COLOR_W-1:0], Green = row[COLOR_W-1:0], Blue = (col+row)[COLOR_W-1:0], with wrap-around truncation.

## Timing
- Reset values while i_rst_n is low at a rising edge:
  - div_cnt, h_cnt, v_cnt, bar counter and latched mode are 0.
  - o_tft_clk = 0, o_DE = 0, colours = 0.
  - o_HS = ~HS_POL and o_VS = ~VS_POL.
  - o_pix_tick = 0, o_frame_start = 0.
- A reset asserted mid-frame restarts from (0,0) with no partial line. The first tick occurs CLK_DIV cycles after reset release.
- Latency: a coordinate is presented for one full pixel period (CLK_DIV cycles) before the tick. Panel outputs change 1 i_clk after the tick edge and are held for CLK_DIV cycles.
- Panel outputs change when o_tft_clk falls and are stable at its rising edge.
- o_pix_tick and o_frame_start are registered and high in the cycle the outputs update.

## Test plan
Bench parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), CLK_DIV 2, COLOR_W 8, CHK_SHIFT 1, both polarities 0.

- **Reset:** hold i_rst_n=0 for 5 cycles → HS=VS=1, DE=0, colours 0, o_tft_clk=0. First o_pix_tick occurs 2 cycles after release, and o_frame_start fires with it.
- **Frame geometry:** run 2 frames → frame_start period 196 cycles. DE high for 8 ticks per line on lines 0–3. HS low for ticks 10–11 of every line. VS low for all of line 5.
- **External mode:** feed i_Red = col, i_Green = row, i_Blue = 8'hA5 → o_Red/o_Green track the displayed pixel, e.g. (7,3) shows 7,3,A5. Colours are 0 at col 8–13.
- **Colour bars:** mode 1 with BAR_W 1 → pixel 0 = FFFFFF, pixel 1 = FFFF00, pixel 7 = 000000.
- **Checkerboard and gradient:**
  - Mode 2 → (0,0) white, (2,0) black, (2,2) white.
  - Mode 3 → (5,3) gives R=5, G=3, B=8.
- **Mid-frame mode change:** switch mode 0→1 at line 2 → current frame stays external; bars start at the next o_frame_start.
